bira_solution_emitter: RTL

- Downstream of the BIRA analysis stage; starts once BIST has ended and a spare allocation is final.
- Latches the per-pivot spare allocation (PCAM entries) and serialises it into 16-bit repair solution words.
- Handshake is valid/ready; each physical spare is emitted at most once.
- Reports repairability, a count of the words sent, and a done pulse to the top level.

---
 rtl/bira_solution_emitter_pkg.sv | 28 ++
 rtl/bira_solution_emitter_if.sv | 19 +
 rtl/bira_solution_emitter_pack.sv | 28 ++
 rtl/bira_solution_emitter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bira_solution_emitter_pkg.sv
// ---------------------------------------------------------------------------
// bira_pkg : shared constants and FSM encoding for the BIRA solution emitter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bira_pkg;

  localparam int PCAM      = 8;
  localparam int ADDR_W    = 10;
  localparam int SPARE_W   = 3;
  localparam int BANK_W    = 2;
  localparam int WORD_W    = 16;

  localparam int SPARE_LSB = 13;
  localparam int RC_BIT    = 12;
  localparam int BANK_LSB  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bira_solution_emitter_if.sv
// ---------------------------------------------------------------------------
// bira_sol_if : valid/ready channel carrying 16-bit repair solution words
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bira_sol_if;
  import bira_pkg::*;

  logic              sol_valid;
  logic              sol_ready;
  logic [WORD_W-1:0] solution;

  modport master (output sol_valid, output solution, input sol_ready);
  modport slave  (input sol_valid, input solution, output sol_ready);

endinterface

`default_nettype wire

// File: rtl/bira_solution_emitter_pack.sv
// ---------------------------------------------------------------------------
// solution_word_pack : formats one pivot allocation into a solution word
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module solution_word_pack
  import bira_pkg::*;
(
  input  wire logic [SPARE_W-1:0] spare,
  input  wire logic               rc,
  input  wire logic [BANK_W-1:0]  bank,
  input  wire logic [ADDR_W-1:0]  row,
  input  wire logic [ADDR_W-1:0]  col,
  output logic      [WORD_W-1:0]  word
);

  always_comb begin
    word = '0;
    word[SPARE_LSB +: SPARE_W] = spare;
    word[RC_BIT]               = rc;
    word[BANK_LSB +: BANK_W]   = bank;
    word[ADDR_W-1:0]           = rc ? col : row;
  end

endmodule

`default_nettype wire

// File: rtl/bira_solution_emitter.sv
// ---------------------------------------------------------------------------
// bira_solution_emitter : latches a final spare allocation and streams it out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bira_solution_emitter
  import bira_pkg::*;
#(
  parameter int PCAM   = bira_pkg::PCAM,
  parameter int ADDR_W = bira_pkg::ADDR_W
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     start,
  input  wire logic                     repair_in,
  input  wire logic [PCAM-1:0]          alloc_valid,
  input  wire logic [PCAM-1:0]          alloc_rc,
  input  wire logic [SPARE_W*PCAM-1:0]  alloc_spare,
  input  wire logic [ADDR_W*PCAM-1:0]   pivot_row,
  input  wire logic [ADDR_W*PCAM-1:0]   pivot_col,
  input  wire logic [BANK_W*PCAM-1:0]   pivot_bank,
  bira_sol_if.master                    sol,
  output logic                          busy,
  output logic                          done,
  output logic                          repair,
  output logic [3:0]                    sol_count
);

  state_t state, state_next;

  logic [2:0]               idx;
  logic [PCAM-1:0]          used;
  logic [PCAM-1:0]          lat_valid;
  logic [PCAM-1:0]          lat_rc;
  logic [SPARE_W*PCAM-1:0]  lat_spare;
  logic [ADDR_W*PCAM-1:0]   lat_row;
  logic [ADDR_W*PCAM-1:0]   lat_col;
  logic [BANK_W*PCAM-1:0]   lat_bank;

  logic [SPARE_W-1:0] e_spare [PCAM];
  logic [BANK_W-1:0]  e_bank  [PCAM];
  logic [ADDR_W-1:0]  e_row   [PCAM];
  logic [ADDR_W-1:0]  e_col   [PCAM];

  for (genvar i = 0; i < PCAM; i++) begin : g_entry
    assign e_spare[i] = lat_spare[SPARE_W*i +: SPARE_W];
    assign e_bank[i]  = lat_bank[BANK_W*i +: BANK_W];
    assign e_row[i]   = lat_row[ADDR_W*i +: ADDR_W];
    assign e_col[i]   = lat_col[ADDR_W*i +: ADDR_W];
  end

  logic [SPARE_W-1:0] cur_spare;
  logic [WORD_W-1:0]  cur_word;
  logic               qualify;
  logic               last;

  assign cur_spare = e_spare[idx];
  assign qualify   = lat_valid[idx] && !used[cur_spare];
  assign last      = (idx == 3'(PCAM-1));

  solution_word_pack u_pack (
    .spare (cur_spare),
    .rc    (lat_rc[idx]),
    .bank  (e_bank[idx]),
    .row   (e_row[idx]),
    .col   (e_col[idx]),
    .word  (cur_word)
  );

  // A declined repair still spends one SCAN cycle so done arrives two cycles after start.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_SCAN;
      ST_SCAN: begin
        if (!repair)      state_next = ST_DONE;
        else if (qualify) state_next = ST_EMIT;
        else if (last)    state_next = ST_DONE;
      end
      ST_EMIT: if (sol.sol_ready) state_next = last ? ST_DONE : ST_SCAN;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      used          <= '0;
      lat_valid     <= '0;
      lat_rc        <= '0;
      lat_spare     <= '0;
      lat_row       <= '0;
      lat_col       <= '0;
      lat_bank      <= '0;
      repair        <= 1'b0;
      sol_count     <= '0;
      sol.sol_valid <= 1'b0;
      sol.solution  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          lat_valid <= alloc_valid;
          lat_rc    <= alloc_rc;
          lat_spare <= alloc_spare;
          lat_row   <= pivot_row;
          lat_col   <= pivot_col;
          lat_bank  <= pivot_bank;
          repair    <= repair_in;
          used      <= '0;
          sol_count <= '0;
          idx       <= '0;
        end
        ST_SCAN: if (repair) begin
          if (qualify) begin
            sol.solution  <= cur_word;
            sol.sol_valid <= 1'b1;
          end else if (!last) begin
            idx <= idx + 3'd1;
          end
        end
        ST_EMIT: if (sol.sol_ready) begin
          sol.sol_valid   <= 1'b0;
          used[cur_spare] <= 1'b1;
          sol_count       <= sol_count + 4'd1;
          if (!last) idx <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

`default_nettype wire
